// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and DataMemory.
// The arbiter uses the slave view; the pipeline/loader/memory side uses master.
interface dmem_arbiter_if;
  // Port A (pipeline MEM stage, priority)
  logic        a_req;
  logic        a_we;
  logic [1:0]  a_size;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_ack;
  logic        a_err;
  logic [31:0] a_rdata;
  logic        a_stall;
  // Port B (loader/debug)
  logic        b_req;
  logic        b_we;
  logic [1:0]  b_size;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic        b_err;
  logic [31:0] b_rdata;
  // DataMemory side
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_write;
  logic [1:0]  mem_data;
  logic [31:0] mem_data_out;

  modport slave (
    input  a_req, a_we, a_size, a_addr, a_wdata,
    input  b_req, b_we, b_size, b_addr, b_wdata,
    input  mem_data_out,
    output a_ack, a_err, a_rdata, a_stall,
    output b_ack, b_err, b_rdata,
    output mem_address, mem_data_in, mem_write, mem_data
  );

  modport master (
    output a_req, a_we, a_size, a_addr, a_wdata,
    output b_req, b_we, b_size, b_addr, b_wdata,
    output mem_data_out,
    input  a_ack, a_err, a_rdata, a_stall,
    input  b_ack, b_err, b_rdata,
    input  mem_address, mem_data_in, mem_write, mem_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer in front of DataMemory.
// Port A has priority; port B is guaranteed a grant after at most STARVE_LIMIT
// consecutive A grants. Each access runs IDLE -> ISSUE -> RESP; illegal or
// misaligned requests skip ISSUE and answer with err set, never touching memory.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

  // Size 11 is reserved; halves need even addresses, words 4-byte alignment.
  function automatic logic illegal_req(input logic [1:0] size, input logic [1:0] lsb);
    return (size == 2'b11) | ((size == 2'b01) & lsb[0]) | ((size == 2'b10) & (lsb != 2'b00));
  endfunction

  // DataMemory write code: byte 01, half 10, word 11.
  function automatic logic [1:0] write_code(input logic [1:0] size);
    return {(size == 2'b10) | (size == 2'b01), size != 2'b01};
  endfunction

  logic [1:0]  r_state;
  logic        r_owner_b;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [3:0]  r_streak;
  logic        r_we;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_any;
  logic        w_pick_b;
  logic        w_sel_we;
  logic [1:0]  w_sel_size;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_illegal;
  logic [3:0]  w_streak_nxt;
  logic        w_issue;
  logic        w_resp;
  logic        w_ack_a;
  logic        w_ack_b;

  assign w_any       = bus.a_req | bus.b_req;
  assign w_pick_b    = bus.b_req & (~bus.a_req | (r_streak == LIMIT));
  assign w_sel_we    = w_pick_b ? bus.b_we    : bus.a_we;
  assign w_sel_size  = w_pick_b ? bus.b_size  : bus.a_size;
  assign w_sel_addr  = w_pick_b ? bus.b_addr  : bus.a_addr;
  assign w_sel_wdata = w_pick_b ? bus.b_wdata : bus.a_wdata;
  assign w_illegal   = illegal_req(w_sel_size, w_sel_addr[1:0]);

  // Streak of A grants made while B was waiting; saturates at the limit.
  always_comb begin
    w_streak_nxt = 4'd0;
    if (!w_pick_b && bus.b_req) begin
      w_streak_nxt = (r_streak == LIMIT) ? LIMIT : 4'(r_streak + 4'd1);
    end
  end

  // Sequencer state, owner, status and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner_b <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_streak  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner_b <= w_pick_b;
            r_err     <= w_illegal;
            r_rdata   <= '0;
            r_streak  <= w_streak_nxt;
            r_state   <= w_illegal ? S_RESP : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!r_we) r_rdata <= bus.mem_data_out;
          r_state <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Winner's request fields, held for the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_any) begin
      r_we    <= w_sel_we;
      r_size  <= w_sel_size;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
    end
  end

  assign w_issue = (r_state == S_ISSUE);
  assign w_resp  = (r_state == S_RESP);
  assign w_ack_a = w_resp & ~r_owner_b;
  assign w_ack_b = w_resp & r_owner_b;

  assign bus.a_ack   = w_ack_a;
  assign bus.a_err   = w_ack_a & r_err;
  assign bus.a_rdata = w_ack_a ? r_rdata : 32'd0;
  assign bus.a_stall = bus.a_req & ~w_ack_a;
  assign bus.b_ack   = w_ack_b;
  assign bus.b_err   = w_ack_b & r_err;
  assign bus.b_rdata = w_ack_b ? r_rdata : 32'd0;

  // Memory is driven only in ISSUE; reset blocks a store in flight.
  assign bus.mem_address = w_issue ? r_addr  : 32'd0;
  assign bus.mem_data_in = w_issue ? r_wdata : 32'd0;
  assign bus.mem_data    = w_issue ? r_size  : 2'b00;
  assign bus.mem_write   = (w_issue & r_we & ~reset) ? write_code(r_size) : 2'b00;

endmodule
